led_pattern_engine: RTL and testbench

Parametrised successor to the board's flowing-water LED driver. It drives an N-bit LED bar in one of four animation modes: rotate left, rotate right, bounce, and fill bar. It has a selectable step rate and debounced start/pause, stop and mode buttons. It sits directly between the board push-buttons/switches and the LED pins.

---
 rtl/led_pattern_engine.sv | 247 ++++++++++++++++++++++++
 tb/tb_led_pattern_engine.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_engine.sv
// LED bar animation engine: three debounced push-buttons drive a small
// run/pause/idle controller that animates an N-bit LED bar in one of four
// modes (rotate left, rotate right, bounce, fill) at a switch-selected rate.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | bar dark, tick counter cleared, mode may be changed
// RUN   | tick counter running, bar advances one step per tick
// PAUSE | bar frozen, tick counter held so RUN resumes mid-period

module led_btn_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] CNT_MAX = DW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          deb;
  logic          deb_prev;
  logic [DW-1:0] cnt;

  // Synchronise the raw level, filter it, and emit a one-cycle rising-edge pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      deb      <= 1'b0;
      deb_prev <= 1'b0;
      cnt      <= '0;
      pulse    <= 1'b0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      if (sync2 != deb) begin
        if (cnt == CNT_MAX) begin
          deb <= sync2;
          cnt <= '0;
        end else begin
          cnt <= cnt + DW'(1);
        end
      end else begin
        cnt <= '0;
      end
      deb_prev <= deb;
      pulse    <= deb & ~deb_prev;
    end
  end

endmodule

module led_pattern_engine #(
  parameter int N_LEDS     = 8,
  parameter int TICK_DIV   = 100000000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_start,
  input  logic              btn_stop,
  input  logic              btn_mode,
  input  logic [1:0]        speed,
  output logic [N_LEDS-1:0] led,
  output logic [1:0]        state_o,
  output logic [1:0]        mode_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    MD_LEFT   = 2'd0,
    MD_RIGHT  = 2'd1,
    MD_BOUNCE = 2'd2,
    MD_FILL   = 2'd3
  } mode_t;

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [N_LEDS-1:0] LSB_ONLY = {{(N_LEDS-1){1'b0}}, 1'b1};
  localparam logic [N_LEDS-1:0] MSB_ONLY = {1'b1, {(N_LEDS-1){1'b0}}};

  logic start_p;
  logic stop_p;
  logic mode_p;

  state_t             state_q, state_d;
  mode_t              mode_q,  mode_d;
  logic [N_LEDS-1:0]  led_q,   led_d;
  logic               dir_q,   dir_d;     // 0 = moving up (towards MSB), 1 = down
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  logic [31:0]        period;
  logic [31:0]        period_m1;
  logic [31:0]        cnt_ext;
  logic               tick;
  logic [N_LEDS-1:0]  step_led;

  led_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_start (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_start),
    .pulse (start_p)
  );

  led_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_stop (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_stop),
    .pulse (stop_p)
  );

  led_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_mode),
    .pulse (mode_p)
  );

  function automatic logic [N_LEDS-1:0] init_pat(input mode_t m);
    return (m == MD_RIGHT) ? MSB_ONLY : LSB_ONLY;
  endfunction

  // Step period from the speed switch; >= compare makes a shortened period fire at once.
  always_comb begin
    period = 32'(TICK_DIV) >> speed;
    if (period == 32'd0) begin
      period = 32'd1;
    end
    period_m1 = period - 32'd1;
  end

  assign cnt_ext = 32'(cnt_q);
  assign tick    = (state_q == ST_RUN) && (cnt_ext >= period_m1);

  // Next animation frame for the current mode and direction.
  always_comb begin
    step_led = led_q;
    unique case (mode_q)
      MD_LEFT:   step_led = {led_q[N_LEDS-2:0], led_q[N_LEDS-1]};
      MD_RIGHT:  step_led = {led_q[0], led_q[N_LEDS-1:1]};
      MD_BOUNCE: step_led = dir_q ? (led_q >> 1) : (led_q << 1);
      MD_FILL:   step_led = (&led_q) ? LSB_ONLY : ((led_q << 1) | LSB_ONLY);
      default:   step_led = led_q;
    endcase
  end

  // Controller next-state: stop beats start, start beats a mode reload, reload beats a tick.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    led_d   = led_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;

    if (mode_p) begin
      mode_d = mode_t'(mode_q + 2'd1);
    end

    unique case (state_q)
      ST_IDLE: begin
        led_d = '0;
        cnt_d = '0;
        if (start_p && !stop_p) begin
          state_d = ST_RUN;
          led_d   = init_pat(mode_d);
          dir_d   = 1'b0;
        end
      end

      ST_RUN: begin
        if (stop_p) begin
          state_d = ST_IDLE;
          led_d   = '0;
          cnt_d   = '0;
        end else if (start_p) begin
          state_d = ST_PAUSE;
        end else if (mode_p) begin
          led_d = init_pat(mode_d);
          dir_d = 1'b0;
          cnt_d = '0;
        end else if (tick) begin
          led_d = step_led;
          cnt_d = '0;
          if (mode_q == MD_BOUNCE) begin
            if (!dir_q && step_led[N_LEDS-1]) begin
              dir_d = 1'b1;
            end else if (dir_q && step_led[0]) begin
              dir_d = 1'b0;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_PAUSE: begin
        if (stop_p) begin
          state_d = ST_IDLE;
          led_d   = '0;
          cnt_d   = '0;
        end else if (start_p) begin
          state_d = ST_RUN;
        end else if (mode_p) begin
          led_d = init_pat(mode_d);
          dir_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        led_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Controller state register; reset drops the bar immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MD_LEFT;
      led_q   <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      led_q   <= led_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign led     = led_q;
  assign state_o = state_q;
  assign mode_o  = mode_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed bench for led_pattern_engine with small timing parameters.

module tb_led_pattern_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_stop = 1'b0;
  logic       btn_mode = 1'b0;
  logic [1:0] speed = 2'd0;
  logic [7:0] led;
  logic [1:0] state_o;
  logic [1:0] mode_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  led_pattern_engine #(
    .N_LEDS     (8),
    .TICK_DIV   (8),
    .DEB_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_start (btn_start),
    .btn_stop  (btn_stop),
    .btn_mode  (btn_mode),
    .speed     (speed),
    .led       (led),
    .state_o   (state_o),
    .mode_o    (mode_o)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise the chosen raw buttons, return just after the edge where the FSM acts.
  task automatic press(input logic s, input logic p, input logic m);
    @(posedge clk);
    #1;
    btn_start = s;
    btn_stop  = p;
    btn_mode  = m;
    repeat (8) @(posedge clk);
    #1;
    btn_start = 1'b0;
    btn_stop  = 1'b0;
    btn_mode  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cyc(3);
    n_cmp++; if (led !== 8'h00) begin n_bad++; $display("FAIL reset_led: got %h want %h", led, 8'h00); end
    n_cmp++; if (state_o !== 2'b00) begin n_bad++; $display("FAIL reset_state: got %b want %b", state_o, 2'b00); end
    n_cmp++; if (mode_o !== 2'd0) begin n_bad++; $display("FAIL reset_mode: got %0d want %0d", mode_o, 0); end
    rst = 1'b1;
    cyc(2);
  endtask

  task automatic test_start_left();
    logic [7:0] exp;
    @(posedge clk);
    #1;
    btn_start = 1'b1;
    cyc(7);
    n_cmp++; if (state_o !== 2'b00) begin n_bad++; $display("FAIL start_latency_early: got %b want %b", state_o, 2'b00); end
    cyc(1);
    btn_start = 1'b0;
    n_cmp++; if (state_o !== 2'b01) begin n_bad++; $display("FAIL start_state: got %b want %b", state_o, 2'b01); end
    n_cmp++; if (led !== 8'h01) begin n_bad++; $display("FAIL start_led: got %h want %h", led, 8'h01); end
    cyc(7);
    n_cmp++; if (led !== 8'h01) begin n_bad++; $display("FAIL left_hold: got %h want %h", led, 8'h01); end
    cyc(1);
    n_cmp++; if (led !== 8'h02) begin n_bad++; $display("FAIL left_step1: got %h want %h", led, 8'h02); end
    for (int k = 2; k <= 8; k++) begin
      cyc(8);
      exp = 8'h01 << (k % 8);
      n_cmp++; if (led !== exp) begin n_bad++; $display("FAIL left_step%0d: got %h want %h", k, led, exp); end
    end
  endtask

  task automatic test_mode_right();
    press(1'b0, 1'b0, 1'b1);
    n_cmp++; if (mode_o !== 2'd1) begin n_bad++; $display("FAIL right_mode: got %0d want %0d", mode_o, 1); end
    n_cmp++; if (led !== 8'h80) begin n_bad++; $display("FAIL right_init: got %h want %h", led, 8'h80); end
    cyc(8);
    n_cmp++; if (led !== 8'h40) begin n_bad++; $display("FAIL right_step1: got %h want %h", led, 8'h40); end
    cyc(8);
    n_cmp++; if (led !== 8'h20) begin n_bad++; $display("FAIL right_step2: got %h want %h", led, 8'h20); end
  endtask

  task automatic test_bounce();
    logic [7:0] bseq [15];
    bseq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
             8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    press(1'b0, 1'b0, 1'b1);
    n_cmp++; if (mode_o !== 2'd2) begin n_bad++; $display("FAIL bounce_mode: got %0d want %0d", mode_o, 2); end
    n_cmp++; if (led !== 8'h01) begin n_bad++; $display("FAIL bounce_init: got %h want %h", led, 8'h01); end
    for (int k = 0; k < 15; k++) begin
      cyc(8);
      n_cmp++; if (led !== bseq[k]) begin n_bad++; $display("FAIL bounce_step%0d: got %h want %h", k + 1, led, bseq[k]); end
    end
  endtask

  task automatic test_fill_speed();
    logic [7:0] fseq [8];
    fseq = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h01};
    press(1'b0, 1'b0, 1'b1);
    n_cmp++; if (mode_o !== 2'd3) begin n_bad++; $display("FAIL fill_mode: got %0d want %0d", mode_o, 3); end
    n_cmp++; if (led !== 8'h01) begin n_bad++; $display("FAIL fill_init: got %h want %h", led, 8'h01); end
    for (int k = 0; k < 8; k++) begin
      cyc(8);
      n_cmp++; if (led !== fseq[k]) begin n_bad++; $display("FAIL fill_step%0d: got %h want %h", k + 1, led, fseq[k]); end
    end
    cyc(5);
    n_cmp++; if (led !== 8'h01) begin n_bad++; $display("FAIL speed_pre: got %h want %h", led, 8'h01); end
    speed = 2'd2;
    cyc(1);
    n_cmp++; if (led !== 8'h03) begin n_bad++; $display("FAIL speed_immediate: got %h want %h", led, 8'h03); end
    cyc(1);
    n_cmp++; if (led !== 8'h03) begin n_bad++; $display("FAIL speed_no_double: got %h want %h", led, 8'h03); end
    cyc(1);
    n_cmp++; if (led !== 8'h07) begin n_bad++; $display("FAIL speed_step2: got %h want %h", led, 8'h07); end
    cyc(2);
    n_cmp++; if (led !== 8'h0F) begin n_bad++; $display("FAIL speed_step3: got %h want %h", led, 8'h0F); end
    cyc(2);
    n_cmp++; if (led !== 8'h1F) begin n_bad++; $display("FAIL speed_step4: got %h want %h", led, 8'h1F); end
    speed = 2'd0;
  endtask

  task automatic test_glitch_pause();
    cyc(1);
    btn_start = 1'b1;
    cyc(3);
    btn_start = 1'b0;
    cyc(10);
    n_cmp++; if (state_o !== 2'b01) begin n_bad++; $display("FAIL glitch_state: got %b want %b", state_o, 2'b01); end
    n_cmp++; if (led !== 8'h3F) begin n_bad++; $display("FAIL glitch_led: got %h want %h", led, 8'h3F); end
    press(1'b1, 1'b0, 1'b0);
    n_cmp++; if (state_o !== 2'b10) begin n_bad++; $display("FAIL pause_state: got %b want %b", state_o, 2'b10); end
    n_cmp++; if (led !== 8'h7F) begin n_bad++; $display("FAIL pause_led: got %h want %h", led, 8'h7F); end
    cyc(50);
    n_cmp++; if (state_o !== 2'b10) begin n_bad++; $display("FAIL pause_hold_state: got %b want %b", state_o, 2'b10); end
    n_cmp++; if (led !== 8'h7F) begin n_bad++; $display("FAIL pause_hold_led: got %h want %h", led, 8'h7F); end
    press(1'b1, 1'b0, 1'b0);
    n_cmp++; if (state_o !== 2'b01) begin n_bad++; $display("FAIL resume_state: got %b want %b", state_o, 2'b01); end
    n_cmp++; if (led !== 8'h7F) begin n_bad++; $display("FAIL resume_led: got %h want %h", led, 8'h7F); end
    cyc(1);
    n_cmp++; if (led !== 8'h7F) begin n_bad++; $display("FAIL resume_cnt_hold: got %h want %h", led, 8'h7F); end
    cyc(1);
    n_cmp++; if (led !== 8'hFF) begin n_bad++; $display("FAIL resume_cnt_step: got %h want %h", led, 8'hFF); end
  endtask

  task automatic test_stop_start();
    cyc(8);
    press(1'b1, 1'b1, 1'b1);
    n_cmp++; if (state_o !== 2'b00) begin n_bad++; $display("FAIL stop_start_state: got %b want %b", state_o, 2'b00); end
    n_cmp++; if (led !== 8'h00) begin n_bad++; $display("FAIL stop_start_led: got %h want %h", led, 8'h00); end
    n_cmp++; if (mode_o !== 2'd0) begin n_bad++; $display("FAIL stop_mode_wrap: got %0d want %0d", mode_o, 0); end
    cyc(8);
    press(1'b0, 1'b0, 1'b1);
    n_cmp++; if (mode_o !== 2'd1) begin n_bad++; $display("FAIL idle_mode1: got %0d want %0d", mode_o, 1); end
    n_cmp++; if (led !== 8'h00) begin n_bad++; $display("FAIL idle_mode1_led: got %h want %h", led, 8'h00); end
    cyc(8);
    press(1'b0, 1'b0, 1'b1);
    n_cmp++; if (mode_o !== 2'd2) begin n_bad++; $display("FAIL idle_mode2: got %0d want %0d", mode_o, 2); end
    n_cmp++; if (state_o !== 2'b00) begin n_bad++; $display("FAIL idle_mode2_state: got %b want %b", state_o, 2'b00); end
  endtask

  task automatic test_reset_bounce();
    cyc(8);
    press(1'b1, 1'b0, 1'b0);
    n_cmp++; if (led !== 8'h01) begin n_bad++; $display("FAIL rb_start_led: got %h want %h", led, 8'h01); end
    cyc(64);
    n_cmp++; if (led !== 8'h40) begin n_bad++; $display("FAIL rb_heading_down: got %h want %h", led, 8'h40); end
    #3;
    rst = 1'b0;
    #1;
    n_cmp++; if (led !== 8'h00) begin n_bad++; $display("FAIL async_reset_led: got %h want %h", led, 8'h00); end
    n_cmp++; if (state_o !== 2'b00) begin n_bad++; $display("FAIL async_reset_state: got %b want %b", state_o, 2'b00); end
    n_cmp++; if (mode_o !== 2'd0) begin n_bad++; $display("FAIL async_reset_mode: got %0d want %0d", mode_o, 0); end
    cyc(2);
    rst = 1'b1;
    cyc(2);
  endtask

  task automatic test_back_to_back();
    press(1'b1, 1'b0, 1'b0);
    n_cmp++; if (state_o !== 2'b01) begin n_bad++; $display("FAIL b2b_start_state: got %b want %b", state_o, 2'b01); end
    n_cmp++; if (led !== 8'h01) begin n_bad++; $display("FAIL b2b_start_led: got %h want %h", led, 8'h01); end
    cyc(7);
    press(1'b0, 1'b0, 1'b1);
    n_cmp++; if (mode_o !== 2'd1) begin n_bad++; $display("FAIL b2b_mode: got %0d want %0d", mode_o, 1); end
    n_cmp++; if (led !== 8'h80) begin n_bad++; $display("FAIL b2b_reload_wins: got %h want %h", led, 8'h80); end
    cyc(7);
    n_cmp++; if (led !== 8'h80) begin n_bad++; $display("FAIL b2b_cnt_cleared: got %h want %h", led, 8'h80); end
    cyc(1);
    n_cmp++; if (led !== 8'h40) begin n_bad++; $display("FAIL b2b_next_step: got %h want %h", led, 8'h40); end
  endtask

  initial begin
    test_reset();
    test_start_left();
    test_mode_right();
    test_bounce();
    test_fill_speed();
    test_glitch_pause();
    test_stop_start();
    test_reset_bounce();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
